uart_rx_loader_ctrl: RTL

//  Sequencer behind the UART receiver; consumes its byte stream (rx_done + data).

---
 rtl/uart_loader_pkg.sv | 29 ++
 rtl/loader_timeout_timer.sv | 40 ++++
 rtl/uart_rx_loader_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_loader_pkg
// Shared definitions for the UART program loader:
//   - loader_state_t : FSM state encoding (IDLE=0, COUNT=1, PAYLOAD=2, CHECK=3)
//   - DEF_*          : default byte width, bytes per word and LOAD opcode
//   - word_bits()    : word width derived from byte width and bytes per word
//   - WORD_BITS      : default word width (BYTE_BITS*WORD_BYTES = 32)
// No ports (package).
// -----------------------------------------------------------------------------
package uart_loader_pkg;

    localparam int          DEF_BYTE_BITS  = 8;
    localparam int          DEF_WORD_BYTES = 4;
    localparam logic [7:0]  CMD_LOAD_DEF   = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } loader_state_t;

    function automatic int word_bits(input int byte_bits, input int word_bytes);
        return byte_bits * word_bytes;
    endfunction

    localparam int WORD_BITS = word_bits(DEF_BYTE_BITS, DEF_WORD_BYTES);

endpackage

// File: rtl/loader_timeout_timer.sv
// -----------------------------------------------------------------------------
// loader_timeout_timer
// Inter-byte watchdog for the loader. Counts clocks while enabled and not
// cleared; o_expire is high (combinationally) in the cycle the count has
// reached TIMEOUT_CYCLES-1, unless i_clear is high in that same cycle.
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous reset, active-low
//   i_clear    restart the count (a byte arrived)
//   i_enable   count only while a load is in progress
//   o_expire   1-cycle expiry indication
// -----------------------------------------------------------------------------
module loader_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_expire;

    // A clear in the expiry cycle suppresses the expiry: the byte wins.
    assign w_expire = i_enable && !i_clear && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_expire = w_expire;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear || !i_enable || w_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_loader_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_loader_ctrl
// Sequencer behind the UART receiver. A LOAD opcode byte starts a load: the
// next byte is the word count N, followed by N little-endian words that are
// written to program memory at word addresses 0,1,2,... Any byte received in
// IDLE that is not LOAD is forwarded as a command. A load is aborted if the
// gap between bytes reaches TIMEOUT_CYCLES clocks.
// Optional feature macro: UART_LOADER_CHECKSUM_EN -- adds a CHECK state that
// expects one XOR-of-payload byte after the last word.
// Ports:
//   i_clk          system clock
//   i_reset_n      synchronous reset, active-low
//   i_rx_done      1-cycle pulse, i_rx_data valid
//   i_rx_data      received byte
//   o_mem_we       1-cycle memory write strobe
//   o_mem_addr     memory word address
//   o_mem_wdata    assembled word
//   o_cmd_valid    1-cycle pulse, o_cmd holds a forwarded byte
//   o_cmd          forwarded command byte
//   o_busy         high whenever not IDLE
//   o_load_done    1-cycle pulse, load finished successfully
//   o_err_timeout  1-cycle pulse, load aborted on inter-byte timeout
//   o_err_checksum 1-cycle pulse, checksum mismatch (0 without the feature)
// -----------------------------------------------------------------------------
module uart_rx_loader_ctrl
    import uart_loader_pkg::*;
#(
    parameter int                   BYTE_BITS      = DEF_BYTE_BITS,
    parameter int                   WORD_BYTES     = DEF_WORD_BYTES,
    parameter int                   ADDR_WIDTH     = 8,
    parameter int                   TIMEOUT_CYCLES = 100000,
    parameter logic [BYTE_BITS-1:0] CMD_LOAD       = BYTE_BITS'(CMD_LOAD_DEF)
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset_n,
    input  logic                                       i_rx_done,
    input  logic [BYTE_BITS-1:0]                       i_rx_data,
    output logic                                       o_mem_we,
    output logic [ADDR_WIDTH-1:0]                      o_mem_addr,
    output logic [word_bits(BYTE_BITS, WORD_BYTES)-1:0] o_mem_wdata,
    output logic                                       o_cmd_valid,
    output logic [BYTE_BITS-1:0]                       o_cmd,
    output logic                                       o_busy,
    output logic                                       o_load_done,
    output logic                                       o_err_timeout,
    output logic                                       o_err_checksum
);

    localparam int W_BITS = word_bits(BYTE_BITS, WORD_BYTES);
    localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    loader_state_t          r_state,      w_state_next;
    logic [BIDX_W-1:0]      r_byte_idx,   w_byte_idx_next;
    logic [W_BITS-1:0]      r_word,       w_word_next;
    logic [BYTE_BITS-1:0]   r_words_left, w_words_left_next;
    logic [ADDR_WIDTH-1:0]  r_addr,       w_addr_next;
    logic                   r_mem_we,     w_mem_we_next;
    logic [W_BITS-1:0]      r_mem_wdata,  w_mem_wdata_next;
    logic                   r_cmd_valid,  w_cmd_valid_next;
    logic [BYTE_BITS-1:0]   r_cmd,        w_cmd_next;
    logic                   r_load_done,  w_load_done_next;
`ifdef UART_LOADER_CHECKSUM_EN
    logic                   r_err_chk,    w_err_chk_next;
    logic [BYTE_BITS-1:0]   r_xor,        w_xor_next;
`endif

    logic                   w_expire;
    logic [W_BITS-1:0]      w_word_ins;

    // Current partial word with the incoming byte dropped into its lane.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign w_word_ins[gi*BYTE_BITS +: BYTE_BITS] =
                (r_byte_idx == BIDX_W'(gi)) ? i_rx_data : r_word[gi*BYTE_BITS +: BYTE_BITS];
        end
    endgenerate

    loader_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_rx_done),
        .i_enable  (r_state != ST_IDLE),
        .o_expire  (w_expire)
    );

    always_comb begin
        w_state_next      = r_state;
        w_byte_idx_next   = r_byte_idx;
        w_word_next       = r_word;
        w_words_left_next = r_words_left;
        // The address advances the cycle after each strobe, so the strobe
        // cycle still shows the address the word belongs to.
        w_addr_next       = r_mem_we ? r_addr + 1'b1 : r_addr;
        w_mem_we_next     = 1'b0;
        w_mem_wdata_next  = r_mem_wdata;
        w_cmd_valid_next  = 1'b0;
        w_cmd_next        = r_cmd;
        w_load_done_next  = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        w_err_chk_next    = 1'b0;
        w_xor_next        = r_xor;
`endif

        case (r_state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        w_state_next = ST_COUNT;
                    end else begin
                        w_cmd_valid_next = 1'b1;
                        w_cmd_next       = i_rx_data;
                    end
                end
            end

            ST_COUNT: begin
                if (i_rx_done) begin
                    w_words_left_next = i_rx_data;
                    w_addr_next       = '0;
                    w_byte_idx_next   = '0;
                    w_word_next       = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                    w_xor_next        = '0;
`endif
                    if (i_rx_data == '0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        w_state_next     = ST_CHECK;
`else
                        w_state_next     = ST_IDLE;
                        w_load_done_next = 1'b1;
`endif
                    end else begin
                        w_state_next = ST_PAYLOAD;
                    end
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_PAYLOAD: begin
                if (i_rx_done) begin
                    w_word_next = w_word_ins;
`ifdef UART_LOADER_CHECKSUM_EN
                    w_xor_next  = r_xor ^ i_rx_data;
`endif
                    if (r_byte_idx == BIDX_W'(WORD_BYTES - 1)) begin
                        w_mem_we_next     = 1'b1;
                        w_mem_wdata_next  = w_word_ins;
                        w_byte_idx_next   = '0;
                        w_words_left_next = r_words_left - 1'b1;
                        if (r_words_left == BYTE_BITS'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            w_state_next     = ST_CHECK;
`else
                            w_state_next     = ST_IDLE;
                            w_load_done_next = 1'b1;
`endif
                        end
                    end else begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                    end
                end else if (w_expire) begin
                    // Abort: the partial word is dropped, earlier writes stay.
                    w_state_next    = ST_IDLE;
                    w_byte_idx_next = '0;
                    w_word_next     = '0;
                end
            end

`ifdef UART_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_done) begin
                    w_state_next = ST_IDLE;
                    if (i_rx_data == r_xor) begin
                        w_load_done_next = 1'b1;
                    end else begin
                        w_err_chk_next   = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd        <= '0;
            r_load_done  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_err_chk    <= 1'b0;
            r_xor        <= '0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_byte_idx   <= w_byte_idx_next;
            r_word       <= w_word_next;
            r_words_left <= w_words_left_next;
            r_addr       <= w_addr_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_cmd_valid  <= w_cmd_valid_next;
            r_cmd        <= w_cmd_next;
            r_load_done  <= w_load_done_next;
`ifdef UART_LOADER_CHECKSUM_EN
            r_err_chk    <= w_err_chk_next;
            r_xor        <= w_xor_next;
`endif
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd         = r_cmd;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_load_done   = r_load_done;
    // Timer is only enabled outside IDLE, so this is a load-abort pulse.
    assign o_err_timeout = w_expire;
`ifdef UART_LOADER_CHECKSUM_EN
    assign o_err_checksum = r_err_chk;
`else
    assign o_err_checksum = 1'b0;
`endif

endmodule
